// File: rtl/core_pkg.sv
// core_pkg: shared fetch-unit types and constants
package core_pkg;
  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h00000013;
  typedef enum logic [1:0] {IDLE, REQ, WAIT, HOLD} fetch_state_t;
endpackage

// File: rtl/fetch_unit.sv
// fetch_unit: PC-driven instruction fetch over a single-outstanding req/gnt/rvalid port
// clk, rst              clock, asynchronous active-low reset
// pc_address, flush     current PC and redirect strobe; pc_stall holds the PC
// mem_req/addr/gnt      request channel; mem_rvalid/rdata in-order response
// instr_out/pc/valid    registered instruction to decode, accepted by instr_ready
// fetch_misalign        PC not word aligned; fetch parked until the next flush
module fetch_unit
  import core_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] pc_address,
  input  logic            flush,
  output logic            pc_stall,
  output logic            mem_req,
  output logic [XLEN-1:0] mem_addr,
  input  logic            mem_gnt,
  input  logic            mem_rvalid,
  input  logic [XLEN-1:0] mem_rdata,
  output logic [XLEN-1:0] instr_out,
  output logic [XLEN-1:0] instr_pc,
  output logic            instr_valid,
  input  logic            instr_ready,
  output logic            fetch_misalign
);
  fetch_state_t    state;
  logic            load, discard, misaligned;
  logic [XLEN-1:0] addr_q;
  // The first REQ cycle presents the live PC: it moved on the edge that entered REQ
  // and is stalled from then on, so addr_q keeps it stable across a late flush.
  assign misaligned = load && (pc_address[1:0] != 2'b00);
  assign mem_addr = load ? {pc_address[XLEN-1:2], 2'b00} : addr_q;
  assign mem_req = (state == REQ) && !misaligned;
  assign instr_valid = state == HOLD;
  assign pc_stall = !((state == HOLD) && instr_ready && !flush);
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      load <= 1'b0;
      discard <= 1'b0;
      addr_q <= '0;
      instr_out <= NOP_INSTR;
      instr_pc <= '0;
      fetch_misalign <= 1'b0;
    end else begin
      load <= 1'b0;
      case (state)
        IDLE: if (!fetch_misalign || flush) begin
          state <= REQ;
          load <= 1'b1;
          fetch_misalign <= 1'b0;
        end
        REQ: begin
          addr_q <= mem_addr;
          if (misaligned) begin
            state <= flush ? REQ : IDLE;
            load <= flush;
            fetch_misalign <= !flush;
          end else begin
            if (flush) discard <= 1'b1;
            if (mem_gnt) state <= WAIT;
          end
        end
        WAIT: if (mem_rvalid) begin
          if (discard || flush) begin
            state <= REQ;
            load <= 1'b1;
            discard <= 1'b0;
          end else begin
            state <= HOLD;
            instr_out <= mem_rdata;
            instr_pc <= addr_q;
          end
        end else if (flush) discard <= 1'b1;
        HOLD: if (flush || instr_ready) begin
          state <= REQ;
          load <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed vector tables plus randomized run against a PC/memory reference
module tb_fetch_unit;
  import core_pkg::*;
  typedef struct {
    logic [31:0] f, t, g, rv, rd, rdy, er, ea, ev, eo, ep, es, em;
  } vec_t;
  logic clk = 1'b0, rst = 1'b0, flush = 1'b0, mem_gnt = 1'b0, mem_rvalid = 1'b0, instr_ready = 1'b0;
  logic [31:0] pc, pc_rst = 32'h100, tgt = '0, mem_rdata = '0;
  logic pc_stall, mem_req, instr_valid, fetch_misalign;
  logic [31:0] mem_addr, instr_out, instr_pc;
  int total = 0, bad = 0;
  fetch_unit dut (
    .clk(clk), .rst(rst), .pc_address(pc), .flush(flush), .pc_stall(pc_stall),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid),
    .mem_rdata(mem_rdata), .instr_out(instr_out), .instr_pc(instr_pc),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .fetch_misalign(fetch_misalign)
  );
  always #5 clk = ~clk;
  always @(posedge clk or negedge rst)
    if (!rst) pc <= pc_rst;
    else if (flush) pc <= tgt;
    else if (!pc_stall) pc <= pc + 32'd4;
  function automatic logic [31:0] f(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h00000013;
  endfunction
  function automatic vec_t mk(logic [31:0] fl, logic [31:0] t, logic [31:0] g, logic [31:0] rv,
                              logic [31:0] rd, logic [31:0] rdy, logic [31:0] er, logic [31:0] ea,
                              logic [31:0] ev, logic [31:0] eo, logic [31:0] ep, logic [31:0] es,
                              logic [31:0] em = 0);
    mk = '{fl, t, g, rv, rd, rdy, er, ea, ev, eo, ep, es, em};
  endfunction
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %h want %h", n, a, e);
    end
  endtask
  task automatic apply(input vec_t v, input string tag);
    flush = v.f[0]; tgt = v.t; mem_gnt = v.g[0]; mem_rvalid = v.rv[0];
    mem_rdata = v.rd; instr_ready = v.rdy[0];
    #4;
    chk({tag, ".req"}, 32'(mem_req), v.er);
    if (v.er[0]) chk({tag, ".addr"}, mem_addr, v.ea);
    chk({tag, ".valid"}, 32'(instr_valid), v.ev);
    if (v.ev[0]) begin
      chk({tag, ".instr"}, instr_out, v.eo);
      chk({tag, ".ipc"}, instr_pc, v.ep);
    end
    chk({tag, ".stall"}, 32'(pc_stall), v.es);
    chk({tag, ".misalign"}, 32'(fetch_misalign), v.em);
    @(posedge clk); #1;
  endtask
  task automatic chk_reset(input string tag);
    chk({tag, ".req"}, 32'(mem_req), 0);
    chk({tag, ".addr"}, mem_addr, 0);
    chk({tag, ".valid"}, 32'(instr_valid), 0);
    chk({tag, ".instr"}, instr_out, NOP_INSTR);
    chk({tag, ".ipc"}, instr_pc, 0);
    chk({tag, ".misalign"}, 32'(fetch_misalign), 0);
    chk({tag, ".stall"}, 32'(pc_stall), 1);
  endtask
  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end
  initial begin
    vec_t v[$];
    bit outst, phold;
    int dly, consumed;
    logic [31:0] oaddr, paddr;
    repeat (2) @(posedge clk);
    #1;
    chk_reset("rst0");
    rst = 1'b1;
    v = '{
      mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1),
      mk(0, 0, 1, 0, 0, 0, 1, 'h100, 0, 0, 0, 1),
      mk(0, 0, 0, 1, 'h00500093, 0, 0, 0, 0, 0, 0, 1),
      mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 'h00500093, 'h100, 1),
      mk(0, 0, 0, 0, 0, 1, 0, 0, 1, 'h00500093, 'h100, 0),
      mk(0, 0, 0, 0, 0, 0, 1, 'h104, 0, 0, 0, 1),
      mk(0, 0, 0, 0, 0, 0, 1, 'h104, 0, 0, 0, 1),
      mk(0, 0, 0, 0, 0, 0, 1, 'h104, 0, 0, 0, 1),
      mk(0, 0, 1, 0, 0, 0, 1, 'h104, 0, 0, 0, 1),
      mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1),
      mk(0, 0, 0, 1, 'h00a00113, 0, 0, 0, 0, 0, 0, 1),
      mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 'h00a00113, 'h104, 1),
      mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 'h00a00113, 'h104, 1),
      mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 'h00a00113, 'h104, 1),
      mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 'h00a00113, 'h104, 1),
      mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 'h00a00113, 'h104, 1),
      mk(0, 0, 0, 0, 0, 1, 0, 0, 1, 'h00a00113, 'h104, 0),
      mk(0, 0, 1, 0, 0, 0, 1, 'h108, 0, 0, 0, 1),
      mk(1, 'h200, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1),
      mk(0, 0, 0, 1, 'hdeadbeef, 0, 0, 0, 0, 0, 0, 1),
      mk(0, 0, 1, 0, 0, 0, 1, 'h200, 0, 0, 0, 1),
      mk(0, 0, 0, 1, 'h00300193, 0, 0, 0, 0, 0, 0, 1),
      mk(0, 0, 0, 0, 0, 1, 0, 0, 1, 'h00300193, 'h200, 0),
      mk(0, 0, 1, 0, 0, 0, 1, 'h204, 0, 0, 0, 1),
      mk(1, 'h300, 0, 1, 'h0badc0de, 0, 0, 0, 0, 0, 0, 1),
      mk(0, 0, 1, 0, 0, 0, 1, 'h300, 0, 0, 0, 1),
      mk(0, 0, 0, 1, 'h00400213, 0, 0, 0, 0, 0, 0, 1),
      mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 'h00400213, 'h300, 1),
      mk(1, 'h400, 0, 0, 0, 1, 0, 0, 1, 'h00400213, 'h300, 1),
      mk(1, 'h500, 0, 0, 0, 0, 1, 'h400, 0, 0, 0, 1),
      mk(0, 0, 1, 0, 0, 0, 1, 'h400, 0, 0, 0, 1),
      mk(0, 0, 0, 1, 'h12345678, 0, 0, 0, 0, 0, 0, 1),
      mk(0, 0, 1, 0, 0, 0, 1, 'h500, 0, 0, 0, 1),
      mk(0, 0, 0, 1, 'h00100073, 0, 0, 0, 0, 0, 0, 1),
      mk(0, 0, 0, 0, 0, 1, 0, 0, 1, 'h00100073, 'h500, 0),
      mk(0, 0, 1, 0, 0, 0, 1, 'h504, 0, 0, 0, 1)
    };
    foreach (v[i]) apply(v[i], $sformatf("fetch%0d", i));
    mem_gnt = 1'b0;
    instr_ready = 1'b0;
    #2 rst = 1'b0;
    #1 chk_reset("rst_wait");
    pc_rst = 32'h102;
    @(posedge clk); #1;
    rst = 1'b1;
    v = '{
      mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0),
      mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0),
      mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1),
      mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1),
      mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1),
      mk(1, 'h200, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1),
      mk(0, 0, 1, 0, 0, 0, 1, 'h200, 0, 0, 0, 1, 0),
      mk(0, 0, 0, 1, 'h00000513, 0, 0, 0, 0, 0, 0, 1, 0),
      mk(0, 0, 0, 0, 0, 1, 0, 0, 1, 'h00000513, 'h200, 0, 0),
      mk(0, 0, 0, 0, 0, 0, 1, 'h204, 0, 0, 0, 1, 0)
    };
    foreach (v[i]) apply(v[i], $sformatf("mis%0d", i));
    flush = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b0; instr_ready = 1'b0;
    rst = 1'b0;
    pc_rst = 32'h1000;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    outst = 1'b0; phold = 1'b0; dly = 0; consumed = 0; oaddr = '0; paddr = '0;
    for (int c = 0; c < 3000; c++) begin
      if (mem_req) chk("one_outstanding", 32'(outst), 0);
      if (phold) begin
        chk("req_hold", 32'(mem_req), 1);
        chk("addr_hold", mem_addr, paddr);
      end
      mem_rvalid = 1'b0;
      mem_rdata = 32'hffffffff;
      if (outst) begin
        if (dly == 0) begin
          mem_rvalid = 1'b1;
          mem_rdata = f(oaddr);
          outst = 1'b0;
        end else dly--;
      end else if ($urandom_range(9) == 0) mem_rvalid = 1'b1;
      mem_gnt = mem_req && ($urandom_range(1) == 1);
      if (mem_gnt) begin
        outst = 1'b1;
        oaddr = mem_addr;
        dly = $urandom_range(2);
      end
      instr_ready = $urandom_range(99) < 60;
      flush = $urandom_range(99) < 7;
      tgt = $urandom_range(32'h3fff) << 2;
      #4;
      if (instr_valid) begin
        chk("rnd_instr", instr_out, f(instr_pc));
        chk("rnd_ipc", instr_pc, pc);
        if (instr_ready && !flush) consumed++;
      end
      if (mem_req) chk("rnd_align", 32'(mem_addr[1:0]), 0);
      chk("rnd_stall", 32'(pc_stall), 32'(!(instr_valid && instr_ready && !flush)));
      phold = mem_req && !mem_gnt;
      paddr = mem_addr;
      @(posedge clk); #1;
    end
    chk("progress", 32'(consumed >= 100), 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
